// File: rtl/imem_loader_pkg.sv
// Constants and state type shared by the imem loader and the instruction memory.
package imem_pkg;
  localparam int IMEM_DEPTH  = 64;
  localparam int IMEM_ADDR_W = 6;

  typedef enum logic [2:0] {IDLE, LOAD, WRITE, CHK, DONE} loader_state_t;
endpackage

// File: rtl/imem_loader_if.sv
// Byte-stream handshake plus imem write port. master = host/memory side, slave = loader.
interface imem_loader_if
  import imem_pkg::*;
#(
  parameter int ADDR_W = IMEM_ADDR_W
);
  logic [7:0]        byte_in;
  logic              byte_valid;
  logic              byte_ready;
  logic              imem_we;
  logic [ADDR_W-1:0] imem_waddr;
  logic [31:0]       imem_wdata;

  modport master (output byte_in, byte_valid,
                  input  byte_ready, imem_we, imem_waddr, imem_wdata);
  modport slave  (input  byte_in, byte_valid,
                  output byte_ready, imem_we, imem_waddr, imem_wdata);
endinterface

// File: rtl/imem_loader_byte_packer.sv
// Little-endian byte-to-word packer: byte k of each group of four lands in bits [8k+7:8k].
module imem_byte_packer (
  input  logic        clk_i,
  input  logic        reset_i,
  input  logic        clear_i,
  input  logic        byte_en_i,
  input  logic [7:0]  byte_i,
  output logic [31:0] word_o,
  output logic        word_full_o
);
  logic [1:0]  idx_q, idx_d;
  logic [31:0] word_q, word_d;

  always_comb begin
    idx_d  = idx_q;
    word_d = word_q;
    if (clear_i) begin
      idx_d  = 2'd0;
      word_d = 32'd0;
    end else if (byte_en_i) begin
      word_d[{idx_q, 3'b000} +: 8] = byte_i;
      idx_d = idx_q + 2'd1;
    end
  end

  always_ff @(posedge clk_i) begin
    if (reset_i) begin
      idx_q  <= 2'd0;
      word_q <= 32'd0;
    end else begin
      idx_q  <= idx_d;
      word_q <= word_d;
    end
  end

  // Next-state word so the loader can capture the completed word on the 4th-byte edge.
  assign word_o      = word_d;
  assign word_full_o = byte_en_i && (idx_q == 2'd3);
endmodule

// File: rtl/imem_loader.sv
// Loads a byte stream into imem as 32-bit words while holding the core in reset.
// Optional trailing checksum byte: define IMEM_LOADER_CHECKSUM_EN.
module imem_loader
  import imem_pkg::*;
#(
  parameter int DEPTH  = IMEM_DEPTH,
  parameter int ADDR_W = IMEM_ADDR_W
) (
  input  logic          clk_i,
  input  logic          reset_i,
  input  logic          start_i,
  input  logic [ADDR_W:0] load_len_i,
  imem_loader_if.slave  bus,
  output logic          cpu_hold_o,
  output logic          busy_o,
  output logic          done_o,
  output logic          err_o
);
  localparam logic [ADDR_W:0] LEN_MAX = DEPTH[ADDR_W:0];

  loader_state_t     state_q;
  logic [ADDR_W:0]   len_q, word_cnt_q, cnt_inc;
  logic              byte_ready_q, imem_we_q, cpu_hold_q, busy_q, done_q, err_q;
  logic [ADDR_W-1:0] imem_waddr_q;
  logic [31:0]       imem_wdata_q, pack_word;
  logic              xfer, len_ok, pack_clr, pack_en, pack_full;
`ifdef IMEM_LOADER_CHECKSUM_EN
  logic [7:0]        sum_q;
`endif

  assign xfer     = bus.byte_valid && byte_ready_q;
  assign len_ok   = (load_len_i != '0) && (load_len_i <= LEN_MAX);
  assign pack_clr = (state_q == IDLE) && start_i && len_ok;
  assign pack_en  = (state_q == LOAD) && xfer;
  assign cnt_inc  = word_cnt_q + 1'b1;

  imem_byte_packer u_packer (
    .clk_i      (clk_i),
    .reset_i    (reset_i),
    .clear_i    (pack_clr),
    .byte_en_i  (pack_en),
    .byte_i     (bus.byte_in),
    .word_o     (pack_word),
    .word_full_o(pack_full)
  );

  always_ff @(posedge clk_i) begin
    if (reset_i) begin
      state_q      <= IDLE;
      len_q        <= '0;
      word_cnt_q   <= '0;
      byte_ready_q <= 1'b0;
      imem_we_q    <= 1'b0;
      imem_waddr_q <= '0;
      imem_wdata_q <= '0;
      cpu_hold_q   <= 1'b0;
      busy_q       <= 1'b0;
      done_q       <= 1'b0;
      err_q        <= 1'b0;
`ifdef IMEM_LOADER_CHECKSUM_EN
      sum_q        <= '0;
`endif
    end else begin
      done_q    <= 1'b0;
      imem_we_q <= 1'b0;
      case (state_q)
        IDLE: begin
          if (start_i && len_ok) begin
            state_q      <= LOAD;
            len_q        <= load_len_i;
            word_cnt_q   <= '0;
            err_q        <= 1'b0;
            cpu_hold_q   <= 1'b1;
            busy_q       <= 1'b1;
            byte_ready_q <= 1'b1;
`ifdef IMEM_LOADER_CHECKSUM_EN
            sum_q        <= '0;
`endif
          end else if (start_i) begin
            err_q  <= 1'b1;
            done_q <= 1'b1;
          end
        end
        LOAD: begin
          if (xfer) begin
`ifdef IMEM_LOADER_CHECKSUM_EN
            sum_q <= sum_q + bus.byte_in;
`endif
            if (pack_full) begin
              state_q      <= WRITE;
              byte_ready_q <= 1'b0;
              imem_we_q    <= 1'b1;
              imem_waddr_q <= word_cnt_q[ADDR_W-1:0];
              imem_wdata_q <= pack_word;
            end
          end
        end
        WRITE: begin
          word_cnt_q <= cnt_inc;
          if (cnt_inc == len_q) begin
`ifdef IMEM_LOADER_CHECKSUM_EN
            state_q      <= CHK;
            byte_ready_q <= 1'b1;
`else
            state_q    <= DONE;
            done_q     <= 1'b1;
            cpu_hold_q <= 1'b0;
`endif
          end else begin
            state_q      <= LOAD;
            byte_ready_q <= 1'b1;
          end
        end
`ifdef IMEM_LOADER_CHECKSUM_EN
        CHK: begin
          if (xfer) begin
            err_q        <= (bus.byte_in != sum_q);
            byte_ready_q <= 1'b0;
            state_q      <= DONE;
            done_q       <= 1'b1;
            cpu_hold_q   <= 1'b0;
          end
        end
`endif
        DONE: begin
          state_q <= IDLE;
          busy_q  <= 1'b0;
        end
        default: state_q <= IDLE;
      endcase
    end
  end

  assign bus.byte_ready = byte_ready_q;
  assign bus.imem_we    = imem_we_q;
  assign bus.imem_waddr = imem_waddr_q;
  assign bus.imem_wdata = imem_wdata_q;
  assign cpu_hold_o     = cpu_hold_q;
  assign busy_o         = busy_q;
  assign done_o         = done_q;
  assign err_o          = err_q;
endmodule
